// File: rtl/uart_cmd_pkg.sv
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared widths, command record, scheduler state encoding and
//                default error byte for the UART command path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    localparam int c_OPC_W  = 2;
    localparam int c_OPND_W = 3;
    localparam int c_RES_W  = 6;
    localparam int c_CMD_W  = c_OPC_W + 2 * c_OPND_W;

    // One buffered command as it travels from the RX parser to the ALU
    typedef struct packed {
        logic [c_OPC_W-1:0]  opcode;
        logic [c_OPND_W-1:0] op1;
        logic [c_OPND_W-1:0] op2;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_TX  = 3'd5
    } state_t;

    localparam logic [7:0] c_DEFAULT_ERR_BYTE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
//  Module      : cmd_fifo
//  Description : Single-clock FIFO with extra-bit pointers; full/empty/level
//                are derived from the registered pointers only.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push_en;
    logic             w_pop_en;

    // Full when the pointers differ only in the wrap bit
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    // A push while full is refused even if a pop happens in the same cycle
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;

    // Pointer update; the extra bit makes the natural wrap modulo 2*DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_scheduler.sv
// ============================================================================
//  Module      : alu_cmd_scheduler
//  Description : Buffers parsed UART commands, issues them one at a time to
//                the shared ALU, and returns each result (or an error byte on
//                timeout) to the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_scheduler
    import uart_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [7:0] ERR_BYTE    = c_DEFAULT_ERR_BYTE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_cmd_valid,
    input  logic [1:0]                    rx_opcode,
    input  logic [2:0]                    rx_op1,
    input  logic [2:0]                    rx_op2,
    output logic                          rx_cmd_ready,
    output logic                          alu_cmd_valid,
    output logic [1:0]                    alu_opcode,
    output logic [2:0]                    alu_op1,
    output logic [2:0]                    alu_op2,
    input  logic                          alu_cmd_ack,
    input  logic                          alu_start_tx,
    input  logic [5:0]                    alu_result,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    err_count
);

    localparam logic [7:0] c_TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    cmd_t                r_cmd;
    logic [7:0]          r_timer;
    logic [7:0]          r_tx_data;
    logic [7:0]          r_err_count;
    logic                r_alu_cmd_valid;
    logic                r_tx_start;
    logic                r_busy;

    logic [c_CMD_W-1:0]  w_fifo_din;
    logic [c_CMD_W-1:0]  w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_timer_clr;
    logic                w_capture;
    logic                w_load_err;

    assign w_fifo_din = {rx_opcode, rx_op1, rx_op2};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_cmd_valid),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (fifo_level)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and per-cycle control; ack outranks a coincident timeout
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_timer_clr  = 1'b0;
        w_capture    = 1'b0;
        w_load_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_timer_clr  = 1'b1;
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (alu_cmd_ack) begin
                    w_timer_clr = 1'b1;
                    if (alu_start_tx) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_SEND;
                    end else begin
                        w_next_state = ST_WAIT_RES;
                    end
                end else if (r_timer == c_TMO_LAST) begin
                    w_load_err   = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_WAIT_RES: begin
                if (alu_start_tx) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end else if (r_timer == c_TMO_LAST) begin
                    w_load_err   = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_next_state = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: command register, timer, TX byte, error counter, registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd           <= '0;
            r_timer         <= '0;
            r_tx_data       <= '0;
            r_err_count     <= '0;
            r_alu_cmd_valid <= 1'b0;
            r_tx_start      <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            if (w_pop) r_cmd <= cmd_t'(w_fifo_dout);

            if (w_timer_clr)
                r_timer <= '0;
            else if (r_state == ST_WAIT_ACK || r_state == ST_WAIT_RES)
                r_timer <= r_timer + 8'd1;

            if (w_capture)
                r_tx_data <= {2'b00, alu_result};
            else if (w_load_err)
                r_tx_data <= ERR_BYTE;

            if (w_load_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;

            // Valid tracks residency in WAIT_ACK, so it rises out of ISSUE
            // and falls on the edge that leaves WAIT_ACK
            r_alu_cmd_valid <= (w_next_state == ST_WAIT_ACK);
            r_tx_start      <= (r_state == ST_SEND);
            r_busy          <= (w_next_state != ST_IDLE);
        end
    end

    assign rx_cmd_ready  = !w_fifo_full;
    assign alu_cmd_valid = r_alu_cmd_valid;
    assign alu_opcode    = r_cmd.opcode;
    assign alu_op1       = r_cmd.op1;
    assign alu_op2       = r_cmd.op2;
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign busy          = r_busy;
    assign err_count     = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_scheduler.sv
// ============================================================================
//  Module      : tb_alu_cmd_scheduler
//  Description : Directed self-checking bench for alu_cmd_scheduler with a
//                small ALU model (add, ack 1 cycle after valid, result 2
//                cycles after ack) and a UART TX model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_cmd_scheduler;

    logic       clk;
    logic       reset;
    logic       rx_cmd_valid;
    logic [1:0] rx_opcode;
    logic [2:0] rx_op1;
    logic [2:0] rx_op2;
    logic       rx_cmd_ready;
    logic       alu_cmd_valid;
    logic [1:0] alu_opcode;
    logic [2:0] alu_op1;
    logic [2:0] alu_op2;
    logic       alu_cmd_ack;
    logic       alu_start_tx;
    logic [5:0] alu_result;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] err_count;

    alu_cmd_scheduler #(
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (16),
        .ERR_BYTE    (8'hFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_cmd_valid  (rx_cmd_valid),
        .rx_opcode     (rx_opcode),
        .rx_op1        (rx_op1),
        .rx_op2        (rx_op2),
        .rx_cmd_ready  (rx_cmd_ready),
        .alu_cmd_valid (alu_cmd_valid),
        .alu_opcode    (alu_opcode),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_cmd_ack   (alu_cmd_ack),
        .alu_start_tx  (alu_start_tx),
        .alu_result    (alu_result),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ALU model: 0 normal, 1 never ack, 2 ack without result, 3 ack+result together
    int         alu_mode = 0;
    int         valid_age = 0;
    int         win_len = 0;
    int         first_valid_cyc = 0;
    int         last_gap = 0;
    int         issue_cnt = 0;
    int         res_cnt = 0;
    logic [5:0] res_val = '0;
    int         ack_cyc = 0;
    int         start_cyc = 0;

    // TX model
    bit         tx_hold = 0;
    bit         tx_busy = 0;
    int         tx_cnt = 0;
    int         last_tx_done_cyc = -100;
    int         tx_start_cyc = 0;
    bit         prev_tx_start = 0;
    int         pulse_err = 0;
    logic [7:0] tx_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1ns after the edge and drive the models' inputs
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        alu_cmd_ack  = 1'b0;
        alu_start_tx = 1'b0;
        tx_done      = 1'b0;
        if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
                alu_start_tx = 1'b1;
                alu_result   = res_val;
                start_cyc    = cyc;
            end
        end
        if (alu_cmd_valid) begin
            valid_age++;
            if (valid_age == 1) begin
                issue_cnt++;
                first_valid_cyc = cyc;
                last_gap        = cyc - last_tx_done_cyc;
            end
            if (valid_age == 2 && alu_mode != 1) begin
                alu_cmd_ack = 1'b1;
                ack_cyc     = cyc;
                res_val     = 6'(alu_op1) + 6'(alu_op2);
                if (alu_mode == 0) begin
                    res_cnt = 2;
                end else if (alu_mode == 3) begin
                    alu_start_tx = 1'b1;
                    alu_result   = res_val;
                    start_cyc    = cyc;
                end
            end
        end else begin
            if (valid_age != 0) win_len = valid_age;
            valid_age = 0;
        end
        if (tx_start) begin
            if (prev_tx_start) pulse_err++;
            tx_log.push_back(tx_data);
            tx_start_cyc = cyc;
            tx_busy      = 1;
            tx_cnt       = 2;
        end else if (tx_busy && !tx_hold) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done          = 1'b1;
                tx_busy          = 0;
                last_tx_done_cyc = cyc;
            end
        end
        prev_tx_start = tx_start;
    endtask

    task automatic push(input logic [1:0] opc, input logic [2:0] a, input logic [2:0] b);
        int g;
        g = 0;
        rx_cmd_valid = 1'b1;
        rx_opcode    = opc;
        rx_op1       = a;
        rx_op2       = b;
        while (!rx_cmd_ready && g < 200) begin
            tick();
            g++;
        end
        tick();
        rx_cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int g;
        g = 0;
        while (tx_log.size() < n && g < 400) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || tx_busy) && g < 400) begin
            tick();
            g++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        int base;
        int i0;
        int n1;
        int g;

        reset        = 1'b0;
        rx_cmd_valid = 1'b0;
        rx_opcode    = '0;
        rx_op1       = '0;
        rx_op2       = '0;
        alu_cmd_ack  = 1'b0;
        alu_start_tx = 1'b0;
        alu_result   = '0;
        tx_done      = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_ready",  rx_cmd_ready, 1);
        chk("rst_valid",  alu_cmd_valid, 0);
        chk("rst_txstart", tx_start, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_level",  fifo_level, 0);
        chk("rst_err",    err_count, 0);
        chk("rst_fields", {alu_opcode, alu_op1, alu_op2, tx_data}, 0);
        reset = 1'b1;
        tick();

        // Single add 3+3
        pc = cyc;
        push(2'b00, 3'd3, 3'd3);
        chk("single_level", fifo_level, 1);
        wait_tx(1);
        chk("single_byte", tx_log[0], 8'h06);
        chk("single_issue_lat", first_valid_cyc - pc, 3);
        chk("single_tx_lat", tx_start_cyc - start_cyc, 2);
        chk("single_window", win_len, 2);
        wait_idle();
        chk("single_busy", busy, 0);
        chk("single_issues", issue_cnt, 1);

        // Burst with TX held: first command parked in WAIT_TX, four queued
        tx_hold = 1;
        base = tx_log.size();
        i0 = issue_cnt;
        push(2'b00, 3'd1, 3'd2);
        push(2'b00, 3'd7, 3'd7);
        push(2'b00, 3'd5, 3'd0);
        push(2'b00, 3'd4, 3'd6);
        push(2'b00, 3'd6, 3'd3);
        chk("burst_level_full", fifo_level, 4);
        chk("burst_ready_low", rx_cmd_ready, 0);
        rx_cmd_valid = 1'b1;
        rx_opcode    = 2'b00;
        rx_op1       = 3'd2;
        rx_op2       = 3'd2;
        repeat (6) tick();
        chk("burst_hold_level", fifo_level, 4);
        chk("burst_hold_valid", alu_cmd_valid, 0);
        chk("burst_hold_txcnt", tx_log.size(), base + 1);
        tx_hold = 0;
        g = 0;
        while (!rx_cmd_ready && g < 200) begin
            tick();
            g++;
        end
        tick();
        rx_cmd_valid = 1'b0;
        wait_tx(base + 6);
        chk("burst_count", tx_log.size(), base + 6);
        chk("burst_b0", tx_log[base + 0], 8'h03);
        chk("burst_b1", tx_log[base + 1], 8'h0E);
        chk("burst_b2", tx_log[base + 2], 8'h05);
        chk("burst_b3", tx_log[base + 3], 8'h0A);
        chk("burst_b4", tx_log[base + 4], 8'h09);
        chk("burst_b5", tx_log[base + 5], 8'h04);
        chk("burst_done_to_valid", last_gap, 3);
        chk("burst_issues", issue_cnt - i0, 6);
        wait_idle();

        // ACK timeout
        alu_mode = 1;
        n1 = tx_log.size();
        push(2'b00, 3'd1, 3'd1);
        wait_tx(n1 + 1);
        chk("acktmo_window", win_len, 16);
        chk("acktmo_byte", tx_log[n1], 8'hFF);
        chk("acktmo_err", err_count, 1);
        wait_idle();

        // Result timeout, then a normal command
        alu_mode = 2;
        n1 = tx_log.size();
        push(2'b00, 3'd2, 3'd3);
        wait_tx(n1 + 1);
        chk("restmo_byte", tx_log[n1], 8'hFF);
        chk("restmo_err", err_count, 2);
        chk("restmo_lat", tx_start_cyc - ack_cyc, 18);
        wait_idle();
        alu_mode = 0;
        push(2'b00, 3'd2, 3'd5);
        wait_tx(n1 + 2);
        chk("restmo_next_byte", tx_log[n1 + 1], 8'h07);
        chk("restmo_next_err", err_count, 2);
        wait_idle();

        // Ack and result in the same cycle
        alu_mode = 3;
        i0 = issue_cnt;
        n1 = tx_log.size();
        push(2'b00, 3'd4, 3'd4);
        wait_tx(n1 + 1);
        chk("simul_byte", tx_log[n1], 8'h08);
        chk("simul_lat", tx_start_cyc - start_cyc, 2);
        wait_idle();
        chk("simul_issues", issue_cnt - i0, 1);

        // Reset while waiting for a result with two commands queued
        alu_mode = 2;
        push(2'b00, 3'd1, 3'd1);
        push(2'b00, 3'd1, 3'd2);
        push(2'b00, 3'd1, 3'd3);
        repeat (3) tick();
        chk("rstmid_level2", fifo_level, 2);
        chk("rstmid_busy1", busy, 1);
        reset = 1'b0;
        #1;
        chk("rstmid_ready", rx_cmd_ready, 1);
        chk("rstmid_valid", alu_cmd_valid, 0);
        chk("rstmid_txstart", tx_start, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_err", err_count, 0);
        chk("rstmid_fields", {alu_opcode, alu_op1, alu_op2, tx_data}, 0);
        alu_mode  = 0;
        res_cnt   = 0;
        valid_age = 0;
        tx_busy   = 0;
        repeat (2) tick();
        reset = 1'b1;
        n1 = tx_log.size();
        repeat (30) tick();
        chk("rstmid_no_tx", tx_log.size(), n1);
        chk("rstmid_idle", {busy, fifo_level}, 0);
        push(2'b00, 3'd5, 3'd2);
        wait_tx(n1 + 1);
        chk("rstmid_after_byte", tx_log[n1], 8'h07);
        wait_idle();

        // Error counter saturation
        alu_mode = 1;
        for (int k = 0; k < 255; k++) begin
            n1 = tx_log.size();
            push(2'b00, 3'd0, 3'd0);
            wait_tx(n1 + 1);
            wait_idle();
        end
        chk("sat_255", err_count, 255);
        n1 = tx_log.size();
        push(2'b00, 3'd0, 3'd0);
        wait_tx(n1 + 1);
        wait_idle();
        chk("sat_hold", err_count, 255);
        chk("sat_byte", tx_log[n1], 8'hFF);

        chk("tx_pulse_width", pulse_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
